// File: rtl/mem_seg_pkg.sv
// Shared constants for the MEM stage: opcodes, the bubble IR and the bus FSM encoding.
// Optional MEM_TIMEOUT_EN build adds a bus-timeout abort in mem_bus_fsm.
package mem_seg_pkg;

    localparam logic [5:0]  OP_LW     = 6'b100011;
    localparam logic [5:0]  OP_SW     = 6'b101011;
    localparam logic [5:0]  OP_BEQZ   = 6'b000100;

    localparam logic [31:0] BUBBLE_IR = 32'hFFFF_FFFF;

    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_REQ    = 2'd1;
    localparam logic [1:0]  ST_DONE   = 2'd2;

    function automatic logic [5:0] opcode_of(input logic [31:0] ir);
        return ir[31:26];
    endfunction

endpackage

// File: rtl/mem_bus_fsm.sv
// Data-bus sequencer for LW/SW: request/ack handshake, LMD capture, optional timeout.
// With MEM_TIMEOUT_EN defined, a stuck request aborts after TIMEOUT_CYCLES and sets a sticky error.
//
// state   | meaning
// IDLE    | no access in flight; a memory op in the stage register starts one
// REQ     | dbus_req held high, waiting for dbus_ack (or timeout)
// DONE    | access finished; stage register advances this cycle
module mem_bus_fsm #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        is_mem_i,
   input  logic        is_lw_i,
   input  logic        is_sw_i,
   input  logic [31:2] word_addr_i,
   input  logic [31:0] wdata_i,
   input  logic        dbus_ack_i,
   input  logic [31:0] dbus_rdata_i,
   output logic [1:0]  state_o,
   output logic        dbus_req_o,
   output logic [31:0] dbus_addr_o,
   output logic [31:0] dbus_wdata_o,
   output logic        dbus_we_o,
   output logic [31:0] lmd_o,
   output logic        mem_err_o
);
   import mem_seg_pkg::*;

   logic [1:0]  state_q, state_d;
   logic        req_q, req_d;
   logic [31:0] lmd_q, lmd_d;

`ifdef MEM_TIMEOUT_EN
   localparam int            TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] tmr_q, tmr_d;
   logic          err_q, err_d;
`endif

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      lmd_d   = lmd_q;
`ifdef MEM_TIMEOUT_EN
      tmr_d   = tmr_q;
      err_d   = err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (is_mem_i) begin
               state_d = ST_REQ;
               req_d   = 1'b1;
`ifdef MEM_TIMEOUT_EN
               tmr_d   = TMR_LOAD;
`endif
            end
         end
         ST_REQ: begin
            // An ack on the terminal-count edge still completes normally.
            if (dbus_ack_i) begin
               if (is_lw_i) lmd_d = dbus_rdata_i;
               req_d   = 1'b0;
               state_d = ST_DONE;
            end
`ifdef MEM_TIMEOUT_EN
            else if (tmr_q == '0) begin
               req_d   = 1'b0;
               lmd_d   = '0;
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               tmr_d   = tmr_q - 1'b1;
            end
`endif
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(negedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         req_q   <= 1'b0;
         lmd_q   <= '0;
`ifdef MEM_TIMEOUT_EN
         tmr_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         lmd_q   <= lmd_d;
`ifdef MEM_TIMEOUT_EN
         tmr_q   <= tmr_d;
         err_q   <= err_d;
`endif
      end
   end

   assign state_o      = state_q;
   assign dbus_req_o   = req_q;
   assign dbus_addr_o  = {word_addr_i, 2'b00};
   assign dbus_wdata_o = wdata_i;
   assign dbus_we_o    = is_sw_i;
   assign lmd_o        = lmd_q;
`ifdef MEM_TIMEOUT_EN
   assign mem_err_o    = err_q;
`else
   assign mem_err_o    = 1'b0;
`endif

endmodule

// File: rtl/mem_seg.sv
// MEM pipeline stage: EX result register, bus access via mem_bus_fsm, WB outputs and branch resolve.
// MEM_TIMEOUT_EN enables the bus-timeout abort governed by TIMEOUT_CYCLES.
module mem_seg #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] IRi,
   input  logic [31:0] ALUi,
   input  logic [31:0] Bi,
   input  logic        condi,
   output logic        stall_o,
   output logic [31:0] dbus_addr,
   output logic [31:0] dbus_wdata,
   output logic        dbus_we,
   output logic        dbus_req,
   input  logic        dbus_ack,
   input  logic [31:0] dbus_rdata,
   output logic        pc_sel_o,
   output logic [31:0] pc_target_o,
   output logic [31:0] ALUo,
   output logic [31:0] LMDo,
   output logic [31:0] IRo,
   output logic        mem_err_o
);
   import mem_seg_pkg::*;

   logic [31:0] ir_q, ir_d;
   logic [31:0] alu_q, alu_d;
   logic [31:0] b_q, b_d;
   logic        cond_q, cond_d;

   logic [5:0]  op;
   logic        is_lw, is_sw, is_mem, is_br;
   logic [1:0]  bus_state;

   assign op     = opcode_of(ir_q);
   assign is_lw  = (op == OP_LW);
   assign is_sw  = (op == OP_SW);
   assign is_mem = is_lw || is_sw;
   assign is_br  = (op == OP_BEQZ);

   assign stall_o = is_mem && (bus_state != ST_DONE);

   always_comb begin
      ir_d   = ir_q;
      alu_d  = alu_q;
      b_d    = b_q;
      cond_d = cond_q;
      if (!stall_o) begin
         ir_d   = IRi;
         alu_d  = ALUi;
         b_d    = Bi;
         cond_d = condi;
      end
   end

   always_ff @(negedge clk) begin
      if (rst) begin
         ir_q   <= BUBBLE_IR;
         alu_q  <= '0;
         b_q    <= '0;
         cond_q <= 1'b0;
      end else begin
         ir_q   <= ir_d;
         alu_q  <= alu_d;
         b_q    <= b_d;
         cond_q <= cond_d;
      end
   end

   mem_bus_fsm #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_bus (
      .clk          (clk),
      .rst          (rst),
      .is_mem_i     (is_mem),
      .is_lw_i      (is_lw),
      .is_sw_i      (is_sw),
      .word_addr_i  (alu_q[31:2]),
      .wdata_i      (b_q),
      .dbus_ack_i   (dbus_ack),
      .dbus_rdata_i (dbus_rdata),
      .state_o      (bus_state),
      .dbus_req_o   (dbus_req),
      .dbus_addr_o  (dbus_addr),
      .dbus_wdata_o (dbus_wdata),
      .dbus_we_o    (dbus_we),
      .lmd_o        (LMDo),
      .mem_err_o    (mem_err_o)
   );

   // WB only ever sees a completed access; in-flight memory ops look like bubbles.
   assign IRo         = stall_o ? BUBBLE_IR : ir_q;
   assign ALUo        = alu_q;
   assign pc_sel_o    = is_br && cond_q;
   assign pc_target_o = alu_q;

endmodule

// File: tb/tb_mem_seg.sv
// Directed bench for mem_seg: reset, pass-through, LW/SW handshakes, branches, stuck bus, reset mid-access.
// Build with MEM_TIMEOUT_EN to exercise the timeout abort (TIMEOUT_CYCLES=4).
module tb_mem_seg;

   localparam logic [31:0] BUB    = 32'hFFFF_FFFF;
   localparam logic [31:0] I_ADD  = 32'h0022_1820;
   localparam logic [31:0] I_LW   = 32'h8C22_0000;
   localparam logic [31:0] I_SW   = 32'hAC01_0000;
   localparam logic [31:0] I_BEQZ = 32'h1020_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] IRi, ALUi, Bi;
   logic        condi;
   logic        stall_o, dbus_we, dbus_req, dbus_ack, pc_sel_o, mem_err_o;
   logic [31:0] dbus_addr, dbus_wdata, dbus_rdata, pc_target_o, ALUo, LMDo, IRo;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_seg #(
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .IRi         (IRi),
      .ALUi        (ALUi),
      .Bi          (Bi),
      .condi       (condi),
      .stall_o     (stall_o),
      .dbus_addr   (dbus_addr),
      .dbus_wdata  (dbus_wdata),
      .dbus_we     (dbus_we),
      .dbus_req    (dbus_req),
      .dbus_ack    (dbus_ack),
      .dbus_rdata  (dbus_rdata),
      .pc_sel_o    (pc_sel_o),
      .pc_target_o (pc_target_o),
      .ALUo        (ALUo),
      .LMDo        (LMDo),
      .IRo         (IRo),
      .mem_err_o   (mem_err_o)
   );

   // State updates on negedge; sample mid-cycle after the posedge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; IRi = BUB; ALUi = '0; Bi = '0; condi = 1'b0;
      dbus_ack = 1'b0; dbus_rdata = '0;
      tick(); tick(); tick();
      chk("rst_iro",   IRo,       BUB);
      chk("rst_stall", stall_o,   1'b0);
      chk("rst_req",   dbus_req,  1'b0);
      chk("rst_pcsel", pc_sel_o,  1'b0);
      chk("rst_lmd",   LMDo,      32'h0);
      chk("rst_alu",   ALUo,      32'h0);
      chk("rst_err",   mem_err_o, 1'b0);
      rst = 1'b0;

      // ADD passes straight through; a stray ack in IDLE must be ignored
      IRi = I_ADD; ALUi = 32'h7; dbus_ack = 1'b1; dbus_rdata = 32'h5555_5555;
      tick();
      dbus_ack = 1'b0;
      chk("add_alu",   ALUo,     32'h7);
      chk("add_iro",   IRo,      I_ADD);
      chk("add_stall", stall_o,  1'b0);
      chk("add_req",   dbus_req, 1'b0);
      chk("add_lmd",   LMDo,     32'h0);

      // LW, ack arrives on the third REQ cycle: 4 stall cycles
      IRi = I_LW; ALUi = 32'h0000_0103; Bi = 32'h99;
      tick();
      IRi = BUB; ALUi = 32'h0; Bi = 32'h0;
      chk("lw_c1_stall", stall_o,   1'b1);
      chk("lw_c1_iro",   IRo,       BUB);
      chk("lw_c1_req",   dbus_req,  1'b0);
      chk("lw_addr",     dbus_addr, 32'h0000_0100);
      chk("lw_we",       dbus_we,   1'b0);
      tick();
      chk("lw_c2_stall", stall_o,  1'b1);
      chk("lw_c2_req",   dbus_req, 1'b1);
      chk("lw_c2_iro",   IRo,      BUB);
      tick();
      chk("lw_c3_stall", stall_o,  1'b1);
      chk("lw_c3_req",   dbus_req, 1'b1);
      tick();
      chk("lw_c4_stall", stall_o,   1'b1);
      chk("lw_c4_req",   dbus_req,  1'b1);
      chk("lw_c4_addr",  dbus_addr, 32'h0000_0100);
      chk("lw_c4_lmd",   LMDo,      32'h0);
      dbus_ack = 1'b1; dbus_rdata = 32'hDEAD_BEEF;
      tick();
      dbus_ack = 1'b0; dbus_rdata = '0;
      chk("lw_done_stall", stall_o,  1'b0);
      chk("lw_done_req",   dbus_req, 1'b0);
      chk("lw_done_lmd",   LMDo,     32'hDEAD_BEEF);
      chk("lw_done_iro",   IRo,      I_LW);
      tick();
      chk("lw_next_iro",   IRo,      BUB);
      chk("lw_next_stall", stall_o,  1'b0);
      chk("lw_next_lmd",   LMDo,     32'hDEAD_BEEF);

      // SW, ack in the first REQ cycle: 2 stall cycles, req for 1
      IRi = I_SW; ALUi = 32'h40; Bi = 32'h1234;
      tick();
      IRi = BUB; ALUi = 32'h0; Bi = 32'h0;
      chk("sw_c1_stall", stall_o,    1'b1);
      chk("sw_c1_req",   dbus_req,   1'b0);
      chk("sw_we",       dbus_we,    1'b1);
      chk("sw_wdata",    dbus_wdata, 32'h1234);
      chk("sw_addr",     dbus_addr,  32'h40);
      tick();
      chk("sw_c2_stall", stall_o,  1'b1);
      chk("sw_c2_req",   dbus_req, 1'b1);
      dbus_ack = 1'b1; dbus_rdata = 32'h0BAD_0BAD;
      tick();
      dbus_ack = 1'b0; dbus_rdata = '0;
      chk("sw_done_stall", stall_o,  1'b0);
      chk("sw_done_req",   dbus_req, 1'b0);
      chk("sw_done_iro",   IRo,      I_SW);
      chk("sw_done_lmd",   LMDo,     32'hDEAD_BEEF);
      tick();

      // BEQZ taken then not taken
      IRi = I_BEQZ; ALUi = 32'h200; condi = 1'b1;
      tick();
      IRi = BUB; ALUi = 32'h0; condi = 1'b0;
      chk("bt_pcsel",  pc_sel_o,    1'b1);
      chk("bt_target", pc_target_o, 32'h200);
      chk("bt_stall",  stall_o,     1'b0);
      chk("bt_iro",    IRo,         I_BEQZ);
      tick();
      chk("bt_pcsel_1cyc", pc_sel_o, 1'b0);
      IRi = I_BEQZ; ALUi = 32'h300; condi = 1'b0;
      tick();
      IRi = BUB; ALUi = 32'h0;
      chk("bn_pcsel",  pc_sel_o,    1'b0);
      chk("bn_target", pc_target_o, 32'h300);
      tick();

      // LW with no ack at all
      IRi = I_LW; ALUi = 32'h8;
      tick();
      IRi = BUB; ALUi = 32'h0;
      tick();
      chk("to_req_start", dbus_req, 1'b1);
`ifdef MEM_TIMEOUT_EN
      tick(); tick(); tick();
      chk("to_req_c4",   dbus_req,  1'b1);
      chk("to_stall_c4", stall_o,   1'b1);
      chk("to_err_c4",   mem_err_o, 1'b0);
      tick();
      chk("to_req_drop", dbus_req,  1'b0);
      chk("to_err",      mem_err_o, 1'b1);
      chk("to_lmd",      LMDo,      32'h0);
      chk("to_stall",    stall_o,   1'b0);
      chk("to_iro",      IRo,       I_LW);
      tick();
      chk("to_err_sticky", mem_err_o, 1'b1);
      IRi = I_LW; ALUi = 32'h10;
      tick();
      IRi = BUB; ALUi = 32'h0;
      tick();
`else
      for (int i = 0; i < 20; i++) tick();
      chk("hang_req",   dbus_req,  1'b1);
      chk("hang_stall", stall_o,   1'b1);
      chk("hang_err",   mem_err_o, 1'b0);
      chk("hang_lmd",   LMDo,      32'hDEAD_BEEF);
`endif

      // Reset while in REQ, with a simultaneous ack that must not load LMD
      chk("rr_req_before", dbus_req, 1'b1);
      rst = 1'b1; dbus_ack = 1'b1; dbus_rdata = 32'hCAFE_F00D;
      tick();
      chk("rr_req",   dbus_req,  1'b0);
      chk("rr_stall", stall_o,   1'b0);
      chk("rr_lmd",   LMDo,      32'h0);
      chk("rr_iro",   IRo,       BUB);
      chk("rr_err",   mem_err_o, 1'b0);
      rst = 1'b0; dbus_ack = 1'b0; dbus_rdata = '0;
      tick();
      chk("rr_idle_req", dbus_req, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_seg.md
Name: mem_seg

Overview:
- MEM stage of the five-stage R/I/J pipeline. Sits between the EX stage and WB.
- Latches the EX results (ALU result, store data B, IR, zero-condition) and performs LW/SW on the data bus through a req/ack handshake.
- Stalls upstream stages while an access is outstanding.
- Presents ALU result, load data (LMD) and IR to WB, and resolves taken branches (PC select and target) for IF.

Parameters:
- TIMEOUT_CYCLES, 16, cycles in REQ without dbus_ack before abort. Used only with MEM_TIMEOUT_EN.
- OP_LW, 6'b100011, load-word opcode.
- OP_SW, 6'b101011, store-word opcode.
- OP_BEQZ, 6'b000100, branch-if-A-zero opcode.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous reset, active-high.
- IRi  in  32  instruction from EX.
- ALUi  in  32  ALU result from EX (address, arith result or branch target).
- Bi  in  32  store data from EX.
- condi  in  1  EX zero-condition (A==0).
- stall_o  out  1  hold IF/ID/EX stage registers.
- dbus_addr  out  32  word address (ALU[31:2],2'b00).
- dbus_wdata  out  32  store data.
- dbus_we  out  1  1=write.
- dbus_req  out  1  registered request.
- dbus_ack  in  1  access complete; rdata valid this cycle.
- dbus_rdata  in  32  load data.
- pc_sel_o  out  1  branch taken.
- pc_target_o  out  32  branch target.
- ALUo  out  32  to WB.
- LMDo  out  32  to WB.
- IRo  out  32  to WB (32'hFFFF_FFFF = bubble).
- mem_err_o  out  1  sticky bus timeout flag.

Behaviour:
- Clock and reset:
  - All state updates on the falling edge of clk, matching the other stage registers.
  - rst is sampled at that edge.
- Stage register {IR, ALU, B, cond}:
  - Loads from the inputs each edge when stall_o=0.
  - Holds when stall_o=1.
- Reset values:
  - IR = 32'hFFFF_FFFF. ALU, B, LMD = 0. cond = 0.
  - FSM = IDLE, dbus_req = 0, mem_err_o = 0.
  - All outputs settle accordingly: stall_o = 0, pc_sel_o = 0, IRo = 32'hFFFF_FFFF.
- Decode:
  - is_mem = opcode(IR[31:26]) is LW or SW.
  - is_br = opcode is BEQZ.
  - The bubble IR decodes as neither.
- FSM states IDLE, REQ, DONE:
  - IDLE: if is_mem, go to REQ and set dbus_req=1. Otherwise stay in IDLE.
  - REQ: dbus_req, addr, wdata and we are held stable.
    - On dbus_ack with LW: LMD <= dbus_rdata.
    - On dbus_ack with SW: LMD unchanged.
    - On dbus_ack (either): dbus_req <= 0, go to DONE.
  - DONE: go to IDLE. The stage register loads the next instruction at this edge.
- stall_o = is_mem && state != DONE (combinational).
- Latency:
  - Non-memory instructions pass through in 1 cycle.
  - LW/SW occupy at least 3 cycles (IDLE, REQ with immediate ack, DONE).
  - Each extra ack-wait cycle adds 1.
- dbus_we = (opcode == SW). dbus_wdata = B. The low two address bits are forced to 0.
- Outputs:
  - ALUo = ALU.
  - LMDo = LMD.
  - IRo = stall_o ? 32'hFFFF_FFFF : IR, so WB never sees a half-done access.
  - pc_sel_o = is_br && cond.
  - pc_target_o = ALU.
  - pc_sel_o is asserted for exactly one cycle per taken branch.
- A dbus_ack seen outside REQ is ignored.
- rst in REQ: bus request is dropped the same edge, FSM goes to IDLE, and no LMD update occurs.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - A counter clears on REQ entry and increments each cycle in REQ.
  - At TIMEOUT_CYCLES without ack: dbus_req <= 0, LMD <= 0, mem_err_o <= 1 (sticky until rst), go to DONE.
  - An ack on the same edge as the timeout wins (normal completion).
- Undefined:
  - No counter. REQ waits indefinitely.
  - mem_err_o is tied to 0.

Decomposition:
- Shared package holds:
  - the opcode constants OP_LW, OP_SW, OP_BEQZ;
  - BUBBLE_IR = 32'hFFFF_FFFF;
  - the FSM state encoding (2-bit).
- One natural sub-module: mem_bus_fsm (FSM, dbus_req/addr/we, timeout counter, LMD capture). The stage register and output muxing stay in mem_seg.

Test Plan:
- Reset: assert rst for 2 edges → IRo=FFFF_FFFF, stall_o=0, dbus_req=0, pc_sel_o=0, LMDo=0.
- ALU pass-through: IRi = ADD (opcode 0), ALUi=32'h0000_0007 → next cycle ALUo=7, IRo=IRi, stall_o=0, no dbus_req.
- LW with 2-cycle ack delay: ALUi=32'h0000_0103, rdata=32'hDEAD_BEEF.
  - Expect dbus_addr=32'h0000_0100, dbus_we=0.
  - stall_o high for 4 cycles, IRo=bubble meanwhile.
  - Then LMDo=DEAD_BEEF and IRo=LW.
- SW, ack same cycle as req: ALUi=0x40, Bi=0x1234 → dbus_we=1, wdata=0x1234, req held exactly 1 cycle, stall_o 2 cycles.
- BEQZ: condi=1, ALUi=0x200 → pc_sel_o=1 for one cycle, pc_target_o=0x200. With condi=0 → pc_sel_o stays 0.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack → req drops after 4 cycles, mem_err_o=1, LMDo=0, stall released. Separately, rst mid-REQ → dbus_req=0 at that edge.
